// File: rtl/sb_pkg.sv
// Shared types for the store buffer: entry layout and word-offset width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sb_pkg;

    // Byte-offset bits dropped from DataAdrM; the buffer is word granular.
    localparam int WORD_LSB = 2;
    localparam int ADDR_W   = 32 - WORD_LSB;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match search over the buffered stores for M-stage load forwarding.
// Latency: purely combinational.
// Backpressure: none; always produces a result.
module sb_fwd_match
    import sb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  sb_entry_t         entries_i [DEPTH],
    input  logic [AW-1:0]     tail_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_o,
    output logic [31:0]       data_o
);

    logic [AW-1:0] idx;

    // Walk from the oldest slot (tail-DEPTH) to the youngest (tail-1); later
    // matches overwrite earlier ones, so the youngest match wins.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail_i - AW'(k);
            if (entries_i[idx].valid && (entries_i[idx].addr == addr_i)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Circular store FIFO between M stage and data memory, with load forwarding.
// Latency: a store pushed at edge N is presented to memory after edge N.
// Backpressure: StallSB holds the pipeline while full; drains on MemWe & MemReady.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [31:0] DataAdrM,
    input  logic [31:0] WriteDataM,
    input  logic        MemReadM,
    output logic        FwdHitM,
    output logic [31:0] FwdDataM,
    output logic        StallSB,
    output logic        MemWe,
    output logic [31:0] MemAdr,
    output logic [31:0] MemWd,
    input  logic        MemReady,
    output logic        SBEmpty
);

    sb_entry_t     entries_q [DEPTH];
    sb_entry_t     entries_d [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;

    logic          full, empty, push, pop;
    logic          match_hit;
    logic [31:0]   match_data;
    logic          unused_lsb;

    // Loads and stores share DataAdrM; the byte offset is irrelevant here.
    assign unused_lsb = ^DataAdrM[WORD_LSB-1:0];

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    // A full buffer refuses the store even if the head pops this cycle.
    assign push  = MemWriteM & ~full;
    assign pop   = MemWe & MemReady;

    assign StallSB = MemWriteM & full;
    assign SBEmpty = empty;
    assign MemWe   = ~empty;
    assign MemAdr  = empty ? 32'h0 : {entries_q[head_q].addr, {WORD_LSB{1'b0}}};
    assign MemWd   = empty ? 32'h0 : entries_q[head_q].data;

    // Forwarding only sees registered entries, so a same-cycle store is not
    // visible, while a head being popped this cycle still is.
    sb_fwd_match #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fwd (
        .entries_i (entries_q),
        .tail_i    (tail_q),
        .addr_i    (DataAdrM[31:WORD_LSB]),
        .hit_o     (match_hit),
        .data_o    (match_data)
    );

    assign FwdHitM  = MemReadM & match_hit;
    assign FwdDataM = (MemReadM & match_hit) ? match_data : 32'h0;

    // Next-state: retire the head on pop, write the tail on push, track count.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (pop) begin
            entries_d[head_q].valid = 1'b0;
            head_d = head_q + AW'(1);
        end
        if (push) begin
            entries_d[tail_q] = '{valid: 1'b1,
                                  addr:  DataAdrM[31:WORD_LSB],
                                  data:  WriteDataM};
            tail_d = tail_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards every buffered store.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

endmodule
